// File: rtl/mdio_cmd_arbiter_if.sv
// ---------------------------------------------------------------------------
// mdio_cmd_arbiter_if
// Bundles the two requester ports, the two response ports and the engine
// command/status port of mdio_cmd_arbiter.
//   req0_* / req1_* : request handshake (valid/ack) and request fields
//   rsp0_* / rsp1_* : completion pulse with read data and timeout flag
//   eng_*           : command to and status from the mdio frame engine
// Modports:
//   slave  : the arbiter side
//   master : the environment side (requesters plus frame engine)
// ---------------------------------------------------------------------------
interface mdio_cmd_arbiter_if;
    logic        req0_valid;
    logic        req0_wr;
    logic [4:0]  req0_phy_addr;
    logic [4:0]  req0_dev_type;
    logic [15:0] req0_reg_addr;
    logic [15:0] req0_wdata;
    logic        req0_ack;
    logic        rsp0_valid;
    logic [15:0] rsp0_rdata;
    logic        rsp0_err;

    logic        req1_valid;
    logic        req1_wr;
    logic [4:0]  req1_phy_addr;
    logic [4:0]  req1_dev_type;
    logic [15:0] req1_reg_addr;
    logic [15:0] req1_wdata;
    logic        req1_ack;
    logic        rsp1_valid;
    logic [15:0] rsp1_rdata;
    logic        rsp1_err;

    logic        eng_start;
    logic [1:0]  eng_op;
    logic [4:0]  eng_phy_addr;
    logic [4:0]  eng_dev_type;
    logic [15:0] eng_data_in;
    logic        eng_busy;
    logic [15:0] eng_data_out;
    logic        eng_out_valid;

    modport slave (
        input  req0_valid, req0_wr, req0_phy_addr, req0_dev_type, req0_reg_addr, req0_wdata,
        output req0_ack, rsp0_valid, rsp0_rdata, rsp0_err,
        input  req1_valid, req1_wr, req1_phy_addr, req1_dev_type, req1_reg_addr, req1_wdata,
        output req1_ack, rsp1_valid, rsp1_rdata, rsp1_err,
        output eng_start, eng_op, eng_phy_addr, eng_dev_type, eng_data_in,
        input  eng_busy, eng_data_out, eng_out_valid
    );

    modport master (
        output req0_valid, req0_wr, req0_phy_addr, req0_dev_type, req0_reg_addr, req0_wdata,
        input  req0_ack, rsp0_valid, rsp0_rdata, rsp0_err,
        output req1_valid, req1_wr, req1_phy_addr, req1_dev_type, req1_reg_addr, req1_wdata,
        input  req1_ack, rsp1_valid, rsp1_rdata, rsp1_err,
        input  eng_start, eng_op, eng_phy_addr, eng_dev_type, eng_data_in,
        output eng_busy, eng_data_out, eng_out_valid
    );
endinterface

// File: rtl/mdio_cmd_arbiter.sv
// ---------------------------------------------------------------------------
// mdio_cmd_arbiter
// Round-robin arbiter between two requesters in front of the mdio frame
// engine. Each granted transaction is issued as a Clause 45 ADDRESS frame
// followed by a WRITE or READ frame; the completion (read data, timeout flag)
// is returned on the response port of the requester that owns it.
//
// Ports:
//   clk     : block clock
//   reset_n : asynchronous active-low reset
//   bus     : mdio_cmd_arbiter_if.slave (requests, responses, engine port)
//
// Parameters:
//   TIMEOUT_CYCLES : engine stall limit in clk cycles (timeout build only)
//   OP_ADDR/OP_WR/OP_RD : engine opcodes
//
// Build option:
//   MDIO_ARB_TIMEOUT_EN : when defined, every engine wait state is bounded
//                         by TIMEOUT_CYCLES and a stall completes with
//                         err = 1, rdata = 16'hFFFF. When undefined no
//                         counter exists and rsp*_err is always 0.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | waiting for a request while the engine is idle
// A_START  | start pulse for the ADDRESS frame
// A_WAIT_H | waiting for the engine to report busy on the ADDRESS frame
// A_WAIT_L | waiting for the ADDRESS frame to finish
// D_START  | start pulse for the WRITE/READ frame
// D_WAIT_H | waiting for the engine to report busy on the data frame
// D_WAIT_L | waiting for the data frame to finish, capturing read data
// RESP     | completion pulse to the owning requester
// ---------------------------------------------------------------------------
module mdio_cmd_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 20000,
    parameter logic [1:0]  OP_ADDR        = 2'b00,
    parameter logic [1:0]  OP_WR          = 2'b01,
    parameter logic [1:0]  OP_RD          = 2'b11
) (
    input  logic                clk,
    input  logic                reset_n,
    mdio_cmd_arbiter_if.slave   bus
);

    typedef enum logic [2:0] {
        IDLE,
        A_START,
        A_WAIT_H,
        A_WAIT_L,
        D_START,
        D_WAIT_H,
        D_WAIT_L,
        RESP
    } state_t;

    state_t      state_q;
    state_t      state_d;

    logic        owner_q;
    logic        last_q;
    logic        wr_q;
    logic [15:0] wdata_q;
    logic [15:0] rdata_q;
    logic [15:0] rdata_d;
    logic        err_q;
    logic        err_d;

    logic        grant;
    logic        winner;
    logic        timeout;

    // ------------------------------------------------------------------
    // Next state, grant decision and completion data
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        grant   = 1'b0;
        rdata_d = rdata_q;
        err_d   = err_q;

        // On contention the requester not granted last wins.
        if (bus.req0_valid && bus.req1_valid) begin
            winner = ~last_q;
        end else begin
            winner = bus.req1_valid;
        end

        case (state_q)
            IDLE: begin
                if ((bus.req0_valid || bus.req1_valid) && !bus.eng_busy) begin
                    grant   = 1'b1;
                    rdata_d = 16'h0000;
                    err_d   = 1'b0;
                    state_d = A_START;
                end
            end
            A_START: state_d = A_WAIT_H;
            A_WAIT_H: begin
                if (bus.eng_busy) begin
                    state_d = A_WAIT_L;
                end
            end
            A_WAIT_L: begin
                if (!bus.eng_busy) begin
                    state_d = D_START;
                end
            end
            D_START: state_d = D_WAIT_H;
            D_WAIT_H: begin
                if (bus.eng_busy) begin
                    state_d = D_WAIT_L;
                end
            end
            D_WAIT_L: begin
                // The strobe may coincide with busy falling, so the capture
                // goes through rdata_d to reach the response in time.
                if (!wr_q && bus.eng_out_valid) begin
                    rdata_d = bus.eng_data_out;
                end
                if (!bus.eng_busy) begin
                    state_d = RESP;
                end
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (timeout) begin
            state_d = RESP;
            rdata_d = 16'hFFFF;
            err_d   = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // State, captured request and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q          <= IDLE;
            owner_q          <= 1'b0;
            last_q           <= 1'b1;
            wr_q             <= 1'b0;
            wdata_q          <= 16'h0000;
            rdata_q          <= 16'h0000;
            err_q            <= 1'b0;
            bus.req0_ack     <= 1'b0;
            bus.req1_ack     <= 1'b0;
            bus.rsp0_valid   <= 1'b0;
            bus.rsp0_rdata   <= 16'h0000;
            bus.rsp0_err     <= 1'b0;
            bus.rsp1_valid   <= 1'b0;
            bus.rsp1_rdata   <= 16'h0000;
            bus.rsp1_err     <= 1'b0;
            bus.eng_start    <= 1'b0;
            bus.eng_op       <= 2'b00;
            bus.eng_phy_addr <= 5'h00;
            bus.eng_dev_type <= 5'h00;
            bus.eng_data_in  <= 16'h0000;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;

            bus.req0_ack  <= grant && !winner;
            bus.req1_ack  <= grant && winner;
            bus.eng_start <= (state_d == A_START) || (state_d == D_START);

            bus.rsp0_valid <= (state_d == RESP) && !owner_q;
            bus.rsp0_rdata <= ((state_d == RESP) && !owner_q) ? rdata_d : 16'h0000;
            bus.rsp0_err   <= (state_d == RESP) && !owner_q && err_d;
            bus.rsp1_valid <= (state_d == RESP) && owner_q;
            bus.rsp1_rdata <= ((state_d == RESP) && owner_q) ? rdata_d : 16'h0000;
            bus.rsp1_err   <= (state_d == RESP) && owner_q && err_d;

            // The engine address fields are loaded once at grant and then
            // held untouched until the next grant.
            if (grant) begin
                owner_q          <= winner;
                last_q           <= winner;
                wr_q             <= winner ? bus.req1_wr    : bus.req0_wr;
                wdata_q          <= winner ? bus.req1_wdata : bus.req0_wdata;
                bus.eng_op       <= OP_ADDR;
                bus.eng_data_in  <= winner ? bus.req1_reg_addr : bus.req0_reg_addr;
                bus.eng_phy_addr <= winner ? bus.req1_phy_addr : bus.req0_phy_addr;
                bus.eng_dev_type <= winner ? bus.req1_dev_type : bus.req0_dev_type;
            end else if (state_d == D_START) begin
                bus.eng_op      <= wr_q ? OP_WR : OP_RD;
                bus.eng_data_in <= wdata_q;
            end
        end
    end

`ifdef MDIO_ARB_TIMEOUT_EN
    // ------------------------------------------------------------------
    // Wait-state watchdog: down-counter reloaded on entry to every wait
    // state; terminal count forces the transaction to complete with err.
    // ------------------------------------------------------------------
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] tmo_cnt_q;

    function automatic logic is_wait(input state_t s);
        return (s == A_WAIT_H) || (s == A_WAIT_L) || (s == D_WAIT_H) || (s == D_WAIT_L);
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tmo_cnt_q <= '0;
        end else if (is_wait(state_d) && (state_d != state_q)) begin
            tmo_cnt_q <= CNT_W'(TIMEOUT_CYCLES - 1);
        end else if (is_wait(state_q) && (tmo_cnt_q != '0)) begin
            tmo_cnt_q <= tmo_cnt_q - CNT_W'(1);
        end
    end

    assign timeout = is_wait(state_q) && (tmo_cnt_q == '0);
`else
    localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;

    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_mdio_cmd_arbiter.sv
module tb_mdio_cmd_arbiter;
    localparam logic [1:0] OP_ADDR = 2'b00;
    localparam logic [1:0] OP_WR   = 2'b01;
    localparam logic [1:0] OP_RD   = 2'b11;
`ifdef MDIO_ARB_TIMEOUT_EN
    localparam int unsigned TMO = 100;
`else
    localparam int unsigned TMO = 20000;
`endif

    typedef struct {
        bit          wr;
        logic [4:0]  phy;
        logic [4:0]  dev;
        logic [15:0] reg_a;
        logic [15:0] wdata;
    } txn_t;

    typedef struct {
        logic [1:0]  op;
        logic [15:0] data;
        logic [4:0]  phy;
        logic [4:0]  dev;
    } frame_t;

    typedef struct {
        int          who;
        logic [15:0] rdata;
        logic        err;
        int          cyc;
    } rsp_t;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    int   checks  = 0;
    int   errors  = 0;

    mdio_cmd_arbiter_if bus ();

    mdio_cmd_arbiter #(
        .TIMEOUT_CYCLES (TMO),
        .OP_ADDR        (OP_ADDR),
        .OP_WR          (OP_WR),
        .OP_RD          (OP_RD)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    frame_t      frames[$];
    int          grants[$];
    int          grant_cyc[$];
    rsp_t        rsps[$];
    logic [15:0] phy_mem [256];
    logic [15:0] phy_areg [16];
    logic [15:0] ref_mem [256];
    int          eng_cnt;
    logic [1:0]  cur_op;
    logic [15:0] cur_data;
    logic [3:0]  cur_key;
    bit          stick       = 1'b0;
    int          eng_overlap = 0;
    int          last_model  = 1;
    int          cyc_now     = 0;

    function automatic logic [15:0] init_val(input logic [7:0] k);
        if (k == {2'd3, 2'd1, 4'd1}) return 16'h1234;
        return {k ^ 8'h5A, ~k};
    endfunction

    function automatic logic [7:0] mkey(input txn_t t);
        return {t.phy[1:0], t.dev[1:0], t.reg_a[3:0]};
    endfunction

    always @(posedge clk) cyc_now <= cyc_now + 1;

    // Behavioural frame engine + Clause 45 PHY: busy rises the cycle after
    // start and lasts 4..7 cycles; a strobe with data accompanies the end of
    // every frame (junk for ADDRESS and WRITE frames).
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.eng_busy      <= 1'b0;
            bus.eng_out_valid <= 1'b0;
            bus.eng_data_out  <= 16'h0000;
            eng_cnt           <= 0;
            cur_op            <= 2'b00;
            cur_data          <= 16'h0000;
            cur_key           <= 4'h0;
            for (int i = 0; i < 256; i++) phy_mem[i] <= init_val(8'(i));
            for (int i = 0; i < 16; i++) phy_areg[i] <= 16'h0000;
        end else begin
            bus.eng_out_valid <= 1'b0;
            if (bus.eng_start) begin
                if (bus.eng_busy) eng_overlap <= eng_overlap + 1;
                frames.push_back('{op: bus.eng_op, data: bus.eng_data_in,
                                   phy: bus.eng_phy_addr, dev: bus.eng_dev_type});
                cur_op       <= bus.eng_op;
                cur_data     <= bus.eng_data_in;
                cur_key      <= {bus.eng_phy_addr[1:0], bus.eng_dev_type[1:0]};
                bus.eng_busy <= 1'b1;
                eng_cnt      <= int'($urandom_range(7, 4));
            end else if (bus.eng_busy && !stick) begin
                if (eng_cnt > 1) begin
                    eng_cnt <= eng_cnt - 1;
                end else begin
                    bus.eng_busy      <= 1'b0;
                    bus.eng_out_valid <= 1'b1;
                    case (cur_op)
                        OP_ADDR: begin
                            phy_areg[cur_key] <= cur_data;
                            bus.eng_data_out  <= 16'hDEAD;
                        end
                        OP_WR: begin
                            phy_mem[{cur_key, phy_areg[cur_key][3:0]}] <= cur_data;
                            bus.eng_data_out <= 16'hBEEF;
                        end
                        default: bus.eng_data_out <= phy_mem[{cur_key, phy_areg[cur_key][3:0]}];
                    endcase
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic ref_init();
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(8'(i));
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_req0_ack"},   32'(bus.req0_ack), 0);
        chk({tag, "_req1_ack"},   32'(bus.req1_ack), 0);
        chk({tag, "_rsp0_valid"}, 32'(bus.rsp0_valid), 0);
        chk({tag, "_rsp0_rdata"}, 32'(bus.rsp0_rdata), 0);
        chk({tag, "_rsp0_err"},   32'(bus.rsp0_err), 0);
        chk({tag, "_rsp1_valid"}, 32'(bus.rsp1_valid), 0);
        chk({tag, "_rsp1_rdata"}, 32'(bus.rsp1_rdata), 0);
        chk({tag, "_rsp1_err"},   32'(bus.rsp1_err), 0);
        chk({tag, "_eng_start"},  32'(bus.eng_start), 0);
        chk({tag, "_eng_op"},     32'(bus.eng_op), 0);
        chk({tag, "_eng_phy"},    32'(bus.eng_phy_addr), 0);
        chk({tag, "_eng_dev"},    32'(bus.eng_dev_type), 0);
        chk({tag, "_eng_din"},    32'(bus.eng_data_in), 0);
    endtask

    task automatic drive(input int n, input txn_t t);
        if (n == 0) begin
            bus.req0_wr = t.wr; bus.req0_phy_addr = t.phy; bus.req0_dev_type = t.dev;
            bus.req0_reg_addr = t.reg_a; bus.req0_wdata = t.wdata; bus.req0_valid = 1'b1;
        end else begin
            bus.req1_wr = t.wr; bus.req1_phy_addr = t.phy; bus.req1_dev_type = t.dev;
            bus.req1_reg_addr = t.reg_a; bus.req1_wdata = t.wdata; bus.req1_valid = 1'b1;
        end
    endtask

    // After ack the fields are scrambled; the engine must still see the
    // values sampled at ack.
    task automatic scramble(input int n);
        if (n == 0) begin
            bus.req0_valid = 1'b0; bus.req0_wr = 1'($urandom); bus.req0_phy_addr = 5'($urandom);
            bus.req0_dev_type = 5'($urandom); bus.req0_reg_addr = 16'($urandom); bus.req0_wdata = 16'($urandom);
        end else begin
            bus.req1_valid = 1'b0; bus.req1_wr = 1'($urandom); bus.req1_phy_addr = 5'($urandom);
            bus.req1_dev_type = 5'($urandom); bus.req1_reg_addr = 16'($urandom); bus.req1_wdata = 16'($urandom);
        end
    endtask

    function automatic txn_t rand_txn();
        txn_t t;
        t.wr    = 1'($urandom);
        t.phy   = {3'($urandom), 2'($urandom_range(1, 0))};
        t.dev   = {3'($urandom), 2'($urandom_range(1, 0))};
        t.reg_a = {12'($urandom), 4'($urandom_range(3, 0))};
        t.wdata = 16'($urandom);
        return t;
    endfunction

    task automatic run(input int n_rsp, input int budget);
        int cyc = 0;
        int tail = 0;
        bit prev_start = 1'b0;
        bit dbl = 1'b0;
        bit ovl = 1'b0;
        while (cyc < budget && tail < 4) begin
            @(negedge clk);
            cyc++;
            if (bus.req0_ack) begin grants.push_back(0); grant_cyc.push_back(cyc_now); scramble(0); end
            if (bus.req1_ack) begin grants.push_back(1); grant_cyc.push_back(cyc_now); scramble(1); end
            if (bus.rsp0_valid) rsps.push_back('{who: 0, rdata: bus.rsp0_rdata, err: bus.rsp0_err, cyc: cyc_now});
            if (bus.rsp1_valid) rsps.push_back('{who: 1, rdata: bus.rsp1_rdata, err: bus.rsp1_err, cyc: cyc_now});
            if (bus.rsp0_valid && bus.rsp1_valid) ovl = 1'b1;
            if (bus.eng_start && prev_start) dbl = 1'b1;
            prev_start = bus.eng_start;
            if (rsps.size() >= n_rsp) tail++;
        end
        chk("rsp_within_budget", 32'(rsps.size() >= n_rsp), 1);
        chk("rsp_overlap", 32'(ovl), 0);
        chk("eng_start_one_cycle", 32'(dbl), 0);
    endtask

    task automatic clear_logs();
        frames.delete(); grants.delete(); grant_cyc.delete(); rsps.delete();
    endtask

    task automatic do_batch(input bit use0, input txn_t t0, input bit use1, input txn_t t1);
        int order[$];
        txn_t t;
        logic [15:0] exp_rd;
        if (use0 && use1) begin
            if (last_model == 1) begin order.push_back(0); order.push_back(1); end
            else begin order.push_back(1); order.push_back(0); end
        end else if (use1) begin
            order.push_back(1);
        end else begin
            order.push_back(0);
        end
        last_model = order[order.size() - 1];
        clear_logs();
        @(negedge clk);
        if (use0) drive(0, t0);
        if (use1) drive(1, t1);
        run(order.size(), 600);
        chk("grant_count", grants.size(), order.size());
        chk("rsp_count", rsps.size(), order.size());
        chk("frame_count", frames.size(), 2 * order.size());
        for (int i = 0; i < order.size(); i++) begin
            t = (order[i] == 1) ? t1 : t0;
            if (i < grants.size()) chk("grant_order", grants[i], order[i]);
            if (2 * i + 1 < frames.size()) begin
                chk("addr_op",   32'(frames[2*i].op),   32'(OP_ADDR));
                chk("addr_data", 32'(frames[2*i].data), 32'(t.reg_a));
                chk("addr_phy",  32'(frames[2*i].phy),  32'(t.phy));
                chk("addr_dev",  32'(frames[2*i].dev),  32'(t.dev));
                chk("data_op",   32'(frames[2*i+1].op), 32'(t.wr ? OP_WR : OP_RD));
                chk("data_data", 32'(frames[2*i+1].data), 32'(t.wdata));
                chk("data_phy",  32'(frames[2*i+1].phy), 32'(t.phy));
                chk("data_dev",  32'(frames[2*i+1].dev), 32'(t.dev));
            end
            if (i < rsps.size()) begin
                exp_rd = t.wr ? 16'h0000 : ref_mem[mkey(t)];
                chk("rsp_owner", rsps[i].who, order[i]);
                chk("rsp_rdata", 32'(rsps[i].rdata), 32'(exp_rd));
                chk("rsp_err",   32'(rsps[i].err), 0);
            end
            if (t.wr) ref_mem[mkey(t)] = t.wdata;
        end
    endtask

    initial begin
        txn_t t0;
        txn_t t1;
        int   cyc;
        bit   seen;
        int   rsp_cnt;
        bit [1:0] sel;

        bus.req0_valid = 1'b0; bus.req0_wr = 1'b0; bus.req0_phy_addr = '0; bus.req0_dev_type = '0;
        bus.req0_reg_addr = '0; bus.req0_wdata = '0;
        bus.req1_valid = 1'b0; bus.req1_wr = 1'b0; bus.req1_phy_addr = '0; bus.req1_dev_type = '0;
        bus.req1_reg_addr = '0; bus.req1_wdata = '0;
        t0 = '{wr: 1'b0, phy: 5'h00, dev: 5'h00, reg_a: 16'h0000, wdata: 16'h0000};
        t1 = t0;
        ref_init();

        #12;
        check_outputs_zero("reset");
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Host write
        t0 = '{wr: 1'b1, phy: 5'h03, dev: 5'h01, reg_a: 16'h0007, wdata: 16'hA5A5};
        do_batch(1'b1, t0, 1'b0, t1);

        // Read on requester 1, PHY returns 1234
        t1 = '{wr: 1'b0, phy: 5'h03, dev: 5'h01, reg_a: 16'h0001, wdata: 16'h0000};
        do_batch(1'b0, t0, 1'b1, t1);
        if (rsps.size() > 0) chk("read_1234", 32'(rsps[0].rdata), 32'h1234);

        // Contention, four transactions
        for (int k = 0; k < 2; k++) begin
            t0 = rand_txn();
            t1 = rand_txn();
            do_batch(1'b1, t0, 1'b1, t1);
        end

        // Reset during D_WAIT_L of a read
        t0 = '{wr: 1'b0, phy: 5'h01, dev: 5'h02, reg_a: 16'h0005, wdata: 16'h1111};
        clear_logs();
        @(negedge clk);
        drive(0, t0);
        cyc  = 0;
        seen = 1'b0;
        while (cyc < 200 && !seen) begin
            @(negedge clk);
            cyc++;
            if (bus.req0_ack) scramble(0);
            if (frames.size() == 2 && bus.eng_busy) seen = 1'b1;
        end
        chk("reach_data_frame", 32'(seen), 1);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1 check_outputs_zero("midreset");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        last_model = 1;
        ref_init();
        rsp_cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.rsp0_valid || bus.rsp1_valid) rsp_cnt++;
        end
        chk("no_rsp_after_reset", rsp_cnt, 0);
        t0 = rand_txn();
        do_batch(1'b1, t0, 1'b0, t1);

`ifdef MDIO_ARB_TIMEOUT_EN
        // Engine stuck busy after the first start
        stick = 1'b1;
        t0 = rand_txn();
        clear_logs();
        @(negedge clk);
        drive(0, t0);
        run(1, 400);
        last_model = 0;
        chk("tmo_rsp_count", rsps.size(), 1);
        if (rsps.size() > 0 && grant_cyc.size() > 0) begin
            chk("tmo_owner", rsps[0].who, 0);
            chk("tmo_err",   32'(rsps[0].err), 1);
            chk("tmo_rdata", 32'(rsps[0].rdata), 32'hFFFF);
            chk("tmo_latency", 32'((rsps[0].cyc - grant_cyc[0]) >= 95 && (rsps[0].cyc - grant_cyc[0]) <= 110), 1);
        end
        stick = 1'b0;
        t1 = rand_txn();
        do_batch(1'b0, t0, 1'b1, t1);
`endif

        // Randomised mix of single and contended requests
        for (int k = 0; k < 24; k++) begin
            sel = 2'($urandom_range(3, 1));
            t0 = rand_txn();
            t1 = rand_txn();
            do_batch(sel[0], t0, sel[1], t1);
        end

        chk("engine_no_overlap", eng_overlap, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
